// File: rtl/reorder_buffer_pkg.sv
// Shared reorder-buffer constants: default id width and entry type encodings.
package reorder_buffer_pkg;

  localparam int unsigned ROB_WIDTH_BIT_DEF = 4;
  localparam int unsigned ROB_TYPE_BIT      = 2;

  typedef enum logic [ROB_TYPE_BIT-1:0] {
    ROB_TYPE_REG    = 2'd0,
    ROB_TYPE_STORE  = 2'd1,
    ROB_TYPE_BRANCH = 2'd2,
    ROB_TYPE_EXIT   = 2'd3
  } rob_type_e;

endpackage

// File: rtl/reorder_buffer_query_port.sv
// One operand lookup into the ROB, with optional same-cycle broadcast bypass.
module rob_query_port #(
  parameter int unsigned ID_W = 4
) (
  input  logic [ID_W-1:0] i_id,
  input  logic            i_busy,
  input  logic            i_ready,
  input  logic [31:0]     i_value,
  input  logic            i_bypass_en,
  input  logic            i_rs_valid,
  input  logic [ID_W-1:0] i_rs_id,
  input  logic [31:0]     i_rs_value,
  input  logic            i_lsb_valid,
  input  logic [ID_W-1:0] i_lsb_id,
  input  logic [31:0]     i_lsb_value,
  output logic            o_ready,
  output logic [31:0]     o_value
);

  always_comb begin
    o_ready = 1'b0;
    o_value = '0;
    if (i_busy && i_ready) begin
      o_ready = 1'b1;
      o_value = i_value;
    end
    // Broadcasts mirror the writeback rule: only busy entries hit, LSB last so it wins.
    if (i_bypass_en && i_busy) begin
      if (i_rs_valid && (i_rs_id == i_id)) begin
        o_ready = 1'b1;
        o_value = i_rs_value;
      end
      if (i_lsb_valid && (i_lsb_id == i_id)) begin
        o_ready = 1'b1;
        o_value = i_lsb_value;
      end
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocate, capture results, retire one per cycle.
// Optional macro ROB_QUERY_BYPASS_EN lets operand queries see same-cycle broadcasts.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int unsigned ROB_WIDTH_BIT = ROB_WIDTH_BIT_DEF
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     issue_valid,
  input  logic [ROB_TYPE_BIT-1:0]  issue_type,
  input  logic [4:0]               issue_rd,
  input  logic [31:0]              issue_pred_pc,
  output logic [ROB_WIDTH_BIT-1:0] issue_rob_id,
  output logic                     full,
  input  logic                     rs_ready,
  input  logic [ROB_WIDTH_BIT-1:0] rs_rob_id,
  input  logic [31:0]              rs_value,
  input  logic                     lsb_ready,
  input  logic [ROB_WIDTH_BIT-1:0] lsb_rob_id,
  input  logic [31:0]              lsb_value,
  input  logic [ROB_WIDTH_BIT-1:0] q1_id,
  input  logic [ROB_WIDTH_BIT-1:0] q2_id,
  output logic                     q1_ready,
  output logic                     q2_ready,
  output logic [31:0]              q1_value,
  output logic [31:0]              q2_value,
  output logic                     rf_commit_valid,
  output logic [4:0]               rf_commit_rd,
  output logic [31:0]              rf_commit_value,
  output logic [ROB_WIDTH_BIT-1:0] rf_commit_rob_id,
  output logic                     store_commit_valid,
  output logic [ROB_WIDTH_BIT-1:0] store_commit_rob_id,
  output logic                     flush,
  output logic [31:0]              flush_pc,
  output logic                     halt
);

  localparam int unsigned DEPTH = 1 << ROB_WIDTH_BIT;
  localparam logic [ROB_WIDTH_BIT:0]   DEPTH_CNT = (ROB_WIDTH_BIT+1)'(DEPTH);
  localparam logic [ROB_WIDTH_BIT-1:0] ID_ONE    = {{(ROB_WIDTH_BIT-1){1'b0}}, 1'b1};

`ifdef ROB_QUERY_BYPASS_EN
  localparam logic BYPASS_EN = 1'b1;
`else
  localparam logic BYPASS_EN = 1'b0;
`endif

  logic [DEPTH-1:0]         r_busy, r_ready;
  rob_type_e                r_type    [DEPTH];
  logic [4:0]               r_rd      [DEPTH];
  logic [31:0]              r_pred_pc [DEPTH];
  logic [31:0]              r_value   [DEPTH];
  logic [ROB_WIDTH_BIT-1:0] r_head, r_tail;
  logic [ROB_WIDTH_BIT:0]   r_count;

  logic                     r_rf_valid, r_st_valid, r_flush, r_halt;
  logic [4:0]               r_rf_rd;
  logic [31:0]              r_rf_value, r_flush_pc;
  logic [ROB_WIDTH_BIT-1:0] r_rf_id, r_st_id;

  logic                   w_full, w_issue, w_rs_hit, w_lsb_hit, w_commit, w_flush;
  logic [ROB_WIDTH_BIT:0] w_count_nxt;

  assign w_full    = (r_count == DEPTH_CNT);
  assign w_issue   = issue_valid && !w_full;
  assign w_rs_hit  = rs_ready && r_busy[rs_rob_id];
  assign w_lsb_hit = lsb_ready && r_busy[lsb_rob_id];
  assign w_commit  = !r_halt && r_busy[r_head] && r_ready[r_head];
  assign w_flush   = w_commit && (r_type[r_head] == ROB_TYPE_BRANCH) &&
                     (r_value[r_head] != r_pred_pc[r_head]);

  always_comb begin
    w_count_nxt = r_count;
    if (w_issue && !w_commit) begin
      w_count_nxt = r_count + 1'b1;
    end else if (!w_issue && w_commit) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  // Payload needs no reset: it is only observed through busy/ready.
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      if (w_issue) begin
        r_type[r_tail]    <= rob_type_e'(issue_type);
        r_rd[r_tail]      <= issue_rd;
        r_pred_pc[r_tail] <= issue_pred_pc;
      end
      if (w_rs_hit)  r_value[rs_rob_id]  <= rs_value;
      if (w_lsb_hit) r_value[lsb_rob_id] <= lsb_value;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_busy     <= '0;
      r_ready    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_rf_valid <= 1'b0;
      r_rf_rd    <= '0;
      r_rf_value <= '0;
      r_rf_id    <= '0;
      r_st_valid <= 1'b0;
      r_st_id    <= '0;
      r_flush    <= 1'b0;
      r_flush_pc <= '0;
      r_halt     <= 1'b0;
    end else if (!rdy_in) begin
      r_rf_valid <= 1'b0;
      r_st_valid <= 1'b0;
      r_flush    <= 1'b0;
    end else begin
      r_rf_valid <= 1'b0;
      r_st_valid <= 1'b0;
      r_flush    <= 1'b0;
      if (w_issue) begin
        r_busy[r_tail]  <= 1'b1;
        r_ready[r_tail] <= 1'b0;
        r_tail          <= r_tail + ID_ONE;
      end
      if (w_rs_hit)  r_ready[rs_rob_id]  <= 1'b1;
      if (w_lsb_hit) r_ready[lsb_rob_id] <= 1'b1;
      if (w_commit) begin
        r_busy[r_head]  <= 1'b0;
        r_ready[r_head] <= 1'b0;
        r_head          <= r_head + ID_ONE;
        unique case (r_type[r_head])
          ROB_TYPE_REG: begin
            r_rf_valid <= 1'b1;
            r_rf_rd    <= r_rd[r_head];
            r_rf_value <= r_value[r_head];
            r_rf_id    <= r_head;
          end
          ROB_TYPE_STORE: begin
            r_st_valid <= 1'b1;
            r_st_id    <= r_head;
          end
          ROB_TYPE_BRANCH: begin
            if (w_flush) begin
              r_flush    <= 1'b1;
              r_flush_pc <= r_value[r_head];
            end
          end
          ROB_TYPE_EXIT: r_halt <= 1'b1;
        endcase
      end
      r_count <= w_count_nxt;
      // Mispredict squashes everything, including this cycle's issue.
      if (w_flush) begin
        r_busy  <= '0;
        r_ready <= '0;
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end
    end
  end

  rob_query_port #(.ID_W(ROB_WIDTH_BIT)) u_q1 (
    .i_id        (q1_id),
    .i_busy      (r_busy[q1_id]),
    .i_ready     (r_ready[q1_id]),
    .i_value     (r_value[q1_id]),
    .i_bypass_en (BYPASS_EN),
    .i_rs_valid  (rs_ready),
    .i_rs_id     (rs_rob_id),
    .i_rs_value  (rs_value),
    .i_lsb_valid (lsb_ready),
    .i_lsb_id    (lsb_rob_id),
    .i_lsb_value (lsb_value),
    .o_ready     (q1_ready),
    .o_value     (q1_value)
  );

  rob_query_port #(.ID_W(ROB_WIDTH_BIT)) u_q2 (
    .i_id        (q2_id),
    .i_busy      (r_busy[q2_id]),
    .i_ready     (r_ready[q2_id]),
    .i_value     (r_value[q2_id]),
    .i_bypass_en (BYPASS_EN),
    .i_rs_valid  (rs_ready),
    .i_rs_id     (rs_rob_id),
    .i_rs_value  (rs_value),
    .i_lsb_valid (lsb_ready),
    .i_lsb_id    (lsb_rob_id),
    .i_lsb_value (lsb_value),
    .o_ready     (q2_ready),
    .o_value     (q2_value)
  );

  assign issue_rob_id        = r_tail;
  assign full                = w_full;
  assign rf_commit_valid     = r_rf_valid;
  assign rf_commit_rd        = r_rf_rd;
  assign rf_commit_value     = r_rf_value;
  assign rf_commit_rob_id    = r_rf_id;
  assign store_commit_valid  = r_st_valid;
  assign store_commit_rob_id = r_st_id;
  assign flush               = r_flush;
  assign flush_pc            = r_flush_pc;
  assign halt                = r_halt;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer (16 entries).
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

`ifdef ROB_QUERY_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        issue_valid;
  logic [1:0]  issue_type;
  logic [4:0]  issue_rd;
  logic [31:0] issue_pred_pc;
  logic [3:0]  issue_rob_id;
  logic        full;
  logic        rs_ready, lsb_ready;
  logic [3:0]  rs_rob_id, lsb_rob_id, q1_id, q2_id;
  logic [31:0] rs_value, lsb_value, q1_value, q2_value;
  logic        q1_ready, q2_ready;
  logic        rf_commit_valid;
  logic [4:0]  rf_commit_rd;
  logic [31:0] rf_commit_value;
  logic [3:0]  rf_commit_rob_id;
  logic        store_commit_valid;
  logic [3:0]  store_commit_rob_id;
  logic        flush, halt;
  logic [31:0] flush_pc;

  int n_checks = 0;
  int n_fail   = 0;

  reorder_buffer #(.ROB_WIDTH_BIT(4)) dut (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .rdy_in              (rdy_in),
    .issue_valid         (issue_valid),
    .issue_type          (issue_type),
    .issue_rd            (issue_rd),
    .issue_pred_pc       (issue_pred_pc),
    .issue_rob_id        (issue_rob_id),
    .full                (full),
    .rs_ready            (rs_ready),
    .rs_rob_id           (rs_rob_id),
    .rs_value            (rs_value),
    .lsb_ready           (lsb_ready),
    .lsb_rob_id          (lsb_rob_id),
    .lsb_value           (lsb_value),
    .q1_id               (q1_id),
    .q2_id               (q2_id),
    .q1_ready            (q1_ready),
    .q2_ready            (q2_ready),
    .q1_value            (q1_value),
    .q2_value            (q2_value),
    .rf_commit_valid     (rf_commit_valid),
    .rf_commit_rd        (rf_commit_rd),
    .rf_commit_value     (rf_commit_value),
    .rf_commit_rob_id    (rf_commit_rob_id),
    .store_commit_valid  (store_commit_valid),
    .store_commit_rob_id (store_commit_rob_id),
    .flush               (flush),
    .flush_pc            (flush_pc),
    .halt                (halt)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_issue(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] pc);
    issue_valid   = 1'b1;
    issue_type    = t;
    issue_rd      = rd;
    issue_pred_pc = pc;
    tick();
    issue_valid   = 1'b0;
  endtask

  task automatic rs_wb(input logic [3:0] id, input logic [31:0] v);
    rs_ready  = 1'b1;
    rs_rob_id = id;
    rs_value  = v;
    tick();
    rs_ready  = 1'b0;
  endtask

  task automatic check_rf(input string tag, input logic [4:0] rd, input logic [31:0] v,
                          input logic [3:0] id);
    check_eq({tag, "_valid"}, 32'(rf_commit_valid), 32'd1);
    check_eq({tag, "_rd"}, 32'(rf_commit_rd), 32'(rd));
    check_eq({tag, "_value"}, rf_commit_value, v);
    check_eq({tag, "_id"}, 32'(rf_commit_rob_id), 32'(id));
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1;
    issue_valid = 1'b0; issue_type = ROB_TYPE_REG; issue_rd = '0; issue_pred_pc = '0;
    rs_ready = 1'b0; rs_rob_id = '0; rs_value = '0;
    lsb_ready = 1'b0; lsb_rob_id = '0; lsb_value = '0;
    q1_id = '0; q2_id = '0;
    #2;
    check_eq("rst_issue_id", 32'(issue_rob_id), 32'd0);
    check_eq("rst_full", 32'(full), 32'd0);
    check_eq("rst_rf_valid", 32'(rf_commit_valid), 32'd0);
    check_eq("rst_flush", 32'(flush), 32'd0);
    check_eq("rst_halt", 32'(halt), 32'd0);
    tick();
    rst_in = 1'b0;

    // Out-of-order writeback, in-order retire.
    do_issue(ROB_TYPE_REG, 5'd1, 32'd0);
    do_issue(ROB_TYPE_REG, 5'd2, 32'd0);
    do_issue(ROB_TYPE_REG, 5'd3, 32'd0);
    check_eq("t1_tail", 32'(issue_rob_id), 32'd3);
    rs_wb(4'd2, 32'h22);
    check_eq("t1_no_commit_a", 32'(rf_commit_valid), 32'd0);
    rs_wb(4'd0, 32'h11);
    check_eq("t1_no_commit_b", 32'(rf_commit_valid), 32'd0);
    rs_wb(4'd1, 32'h33);
    check_rf("t1_c0", 5'd1, 32'h11, 4'd0);
    tick();
    check_rf("t1_c1", 5'd2, 32'h33, 4'd1);
    tick();
    check_rf("t1_c2", 5'd3, 32'h22, 4'd2);
    tick();
    check_eq("t1_idle", 32'(rf_commit_valid), 32'd0);

    // Fill from head=tail=3: tail wraps, then full.
    for (int i = 0; i < 16; i++) begin
      do_issue(ROB_TYPE_REG, 5'd7, 32'd0);
      if (i == 12) check_eq("t2_wrap", 32'(issue_rob_id), 32'd0);
      if (i == 14) check_eq("t2_not_full", 32'(full), 32'd0);
    end
    check_eq("t2_full", 32'(full), 32'd1);
    issue_valid = 1'b1;
    tick();
    check_eq("t2_17th_ignored", 32'(issue_rob_id), 32'd3);
    check_eq("t2_still_full", 32'(full), 32'd1);
    rs_ready = 1'b1; rs_rob_id = 4'd3; rs_value = 32'h55;
    tick();
    rs_ready = 1'b0;
    tick();
    issue_valid = 1'b0;
    check_rf("t2_commit", 5'd7, 32'h55, 4'd3);
    check_eq("t2_full_drop", 32'(full), 32'd0);
    check_eq("t2_same_cycle_issue_blocked", 32'(issue_rob_id), 32'd3);
    for (int k = 0; k < 15; k++) begin
      logic [3:0] id;
      id = 4'(4 + k);
      rs_wb(id, 32'h100 + 32'(k));
    end
    tick();
    check_eq("t2_drain_last", 32'(rf_commit_rob_id), 32'd2);
    check_eq("t2_drain_last_val", rf_commit_value, 32'h10e);
    tick();
    check_eq("t2_drained", 32'(rf_commit_valid), 32'd0);

    // Mispredicted branch at id 3 with a younger REG behind it.
    do_issue(ROB_TYPE_BRANCH, 5'd0, 32'h100);
    do_issue(ROB_TYPE_REG, 5'd9, 32'd0);
    rs_wb(4'd3, 32'h200);
    issue_valid = 1'b1; issue_type = ROB_TYPE_REG;
    tick();
    issue_valid = 1'b0;
    check_eq("t3_flush", 32'(flush), 32'd1);
    check_eq("t3_flush_pc", flush_pc, 32'h200);
    check_eq("t3_tail_reset", 32'(issue_rob_id), 32'd0);
    q1_id = 4'd4;
    rs_wb(4'd4, 32'h99);
    check_eq("t3_flush_pulse", 32'(flush), 32'd0);
    check_eq("t3_wb_after_flush", 32'(q1_ready), 32'd0);
    check_eq("t3_tail_after_wb", 32'(issue_rob_id), 32'd0);
    do_issue(ROB_TYPE_BRANCH, 5'd0, 32'h100);
    rs_wb(4'd0, 32'h100);
    tick();
    check_eq("t3_no_flush", 32'(flush), 32'd0);
    check_eq("t3_no_flush_tail", 32'(issue_rob_id), 32'd1);

    // Ready store at id 5 must wait for REG at id 4.
    for (int i = 0; i < 3; i++) do_issue(ROB_TYPE_REG, 5'd10, 32'd0);
    for (int k = 1; k < 4; k++) rs_wb(4'(k), 32'(k));
    tick();
    tick();
    check_eq("t4_tail", 32'(issue_rob_id), 32'd4);
    do_issue(ROB_TYPE_REG, 5'd4, 32'd0);
    do_issue(ROB_TYPE_STORE, 5'd0, 32'd0);
    lsb_ready = 1'b1; lsb_rob_id = 4'd5; lsb_value = 32'h5555;
    tick();
    lsb_ready = 1'b0;
    tick();
    check_eq("t4_store_blocked_a", 32'(store_commit_valid), 32'd0);
    tick();
    check_eq("t4_store_blocked_b", 32'(store_commit_valid), 32'd0);
    rs_wb(4'd4, 32'h44);
    tick();
    check_rf("t4_reg", 5'd4, 32'h44, 4'd4);
    check_eq("t4_store_not_yet", 32'(store_commit_valid), 32'd0);
    tick();
    check_eq("t4_store_valid", 32'(store_commit_valid), 32'd1);
    check_eq("t4_store_id", 32'(store_commit_rob_id), 32'd5);
    check_eq("t4_rf_quiet", 32'(rf_commit_valid), 32'd0);
    tick();
    check_eq("t4_store_pulse", 32'(store_commit_valid), 32'd0);

    // Queries; unready head at id 6 keeps ids 7 and 8 resident.
    do_issue(ROB_TYPE_REG, 5'd6, 32'd0);
    do_issue(ROB_TYPE_REG, 5'd7, 32'd0);
    do_issue(ROB_TYPE_REG, 5'd8, 32'd0);
    q1_id = 4'd7;
    rs_ready = 1'b1; rs_rob_id = 4'd7; rs_value = 32'hABCD;
    #1;
    check_eq("t5_bypass_ready", 32'(q1_ready), 32'(BYP));
    check_eq("t5_bypass_value", q1_value, BYP ? 32'hABCD : 32'h0);
    tick();
    rs_ready = 1'b0;
    #1;
    check_eq("t5_stored_ready", 32'(q1_ready), 32'd1);
    check_eq("t5_stored_value", q1_value, 32'hABCD);
    q2_id = 4'd8;
    rs_ready = 1'b1; rs_rob_id = 4'd8; rs_value = 32'h1111;
    lsb_ready = 1'b1; lsb_rob_id = 4'd8; lsb_value = 32'h2222;
    tick();
    rs_ready = 1'b0; lsb_ready = 1'b0;
    #1;
    check_eq("t5_lsb_wins", q2_value, 32'h2222);
    q2_id = 4'd6;
    #1;
    check_eq("t5_unready_q", 32'(q2_ready), 32'd0);
    check_eq("t5_unready_v", q2_value, 32'd0);

    // Freeze with a ready head.
    rs_wb(4'd6, 32'h66);
    rdy_in = 1'b0;
    issue_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("t6_frozen_commit", 32'(rf_commit_valid), 32'd0);
    end
    check_eq("t6_frozen_tail", 32'(issue_rob_id), 32'd9);
    check_eq("t6_frozen_q1", 32'(q1_ready), 32'd1);
    rdy_in = 1'b1;
    issue_valid = 1'b0;
    tick();
    check_rf("t6_c6", 5'd6, 32'h66, 4'd6);
    tick();
    check_rf("t6_c7", 5'd7, 32'hABCD, 4'd7);
    #1;
    rst_in = 1'b1;
    #1;
    check_eq("t6_async_rf", 32'(rf_commit_valid), 32'd0);
    check_eq("t6_async_rd", 32'(rf_commit_rd), 32'd0);
    check_eq("t6_async_tail", 32'(issue_rob_id), 32'd0);
    check_eq("t6_async_q1", 32'(q1_ready), 32'd0);
    tick();
    rst_in = 1'b0;

    // EXIT halts retirement permanently.
    do_issue(ROB_TYPE_EXIT, 5'd0, 32'd0);
    do_issue(ROB_TYPE_REG, 5'd12, 32'd0);
    rs_ready = 1'b1; rs_rob_id = 4'd0; rs_value = 32'd0;
    lsb_ready = 1'b1; lsb_rob_id = 4'd1; lsb_value = 32'h77;
    tick();
    rs_ready = 1'b0; lsb_ready = 1'b0;
    tick();
    check_eq("t7_halt", 32'(halt), 32'd1);
    check_eq("t7_no_rf", 32'(rf_commit_valid), 32'd0);
    tick();
    tick();
    check_eq("t7_halt_sticky", 32'(halt), 32'd1);
    check_eq("t7_no_rf_after", 32'(rf_commit_valid), 32'd0);
    q1_id = 4'd1;
    #1;
    check_eq("t7_reg_resident", 32'(q1_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
